event_byte_packer: RTL and testbench
====================================

// Module: event_byte_packer
// PURPOSE
//  Upstream feeder of the FX2 sequential interface. Buffers 32-bit pulse-event
//  words from the counter core in a word FIFO and serialises each word into bytes
//  on the FPGA_WORD / FPGA_WORD_AVAILIABLE / FPGA_WORD_ACCEPTED handshake.
//  Reports the buffered byte count on LENGTH when the interface requests it, and
//  executes the PC "clear" command decoded from PCINSTRUCTION.
// PARAMETERS
//  ADDR_W      10   log2 of word-FIFO depth (1024 words = 4096 bytes)
//  CLR_BIT     6    PCINSTRUCTION bit that requests buffer clear
// PORTS
//  FX2_CLK              in   1   single clock for the whole block (FX2 IFCLK domain)
//  RESET                in   1   synchronous, active-high reset
//  EVENT_WORD           in   32  event record from counter core, byte 3 = MSB
//  EVENT_VALID          in   1   EVENT_WORD valid this cycle
//  EVENT_READY          out  1   block can take a word this cycle (= ~fifo_full)
//  FPGA_WORD            out  8   current byte offered to the FX2 interface
//  FPGA_WORD_AVAILIABLE out  1   FPGA_WORD is valid
//  FPGA_WORD_ACCEPTED   in   1   interface wrote FPGA_WORD to FIFO4 this edge
//  REQUEST_LENGTH       in   1   latch byte count into LENGTH (1-cycle pulse)
//  LENGTH               out  16  byte count latched at last REQUEST_LENGTH
//  PCINSTRUCTION        in   8   PC command byte, nonzero only on its read cycle
//  OVERFLOW             out  1   sticky: at least one event dropped since clear
// BEHAVIOUR
//  Reset: FIFO empty, serializer empty, FPGA_WORD=8'h00, FPGA_WORD_AVAILIABLE=0,
//   EVENT_READY=1, LENGTH=16'h0000, OVERFLOW=0. Reset mid-transfer discards all.
//  Write side: word written on edge when EVENT_VALID & EVENT_READY. EVENT_READY
//   depends only on registered FIFO count, never on same-cycle read.
//   EVENT_VALID & ~EVENT_READY -> word dropped, OVERFLOW<=1.
//  Serializer: regs word_q[31:0], idx[1:0], full_q. FPGA_WORD = word_q byte idx,
//   order MSB first (idx 0 -> [31:24] ... idx 3 -> [7:0]).
//   FPGA_WORD_AVAILIABLE = full_q (registered; no comb path from ACCEPTED).
//   On ACCEPTED with full_q: idx<3 -> idx+1; idx==3 -> load next FIFO word
//   (idx=0, full_q=1) if FIFO non-empty, else full_q=0. No bubble between words.
//   full_q==0 & FIFO non-empty -> load on next edge.
//   ACCEPTED while full_q==0 is a protocol error: ignored, no state change.
//  Latency: word written at edge N into empty block -> AVAILIABLE high after N+2.
//  FIFO: dual-port RAM, registered read, show-ahead via a one-word output
//   register; word count 0..2^ADDR_W. Simultaneous write and read: count unchanged.
//  Byte count: bytes = 4*fifo_count + (full_q ? 4-idx : 0), 17-bit arithmetic,
//   saturated to 16'hFFFF. On edge with REQUEST_LENGTH=1, LENGTH<=bytes
//   (value before that edge's accept/write). LENGTH holds otherwise.
//  Clear: edge with PCINSTRUCTION[CLR_BIT]=1 -> FIFO and serializer emptied,
//   OVERFLOW<=0, LENGTH unchanged. Clear wins over same-cycle write and accept
//   (both discarded, no OVERFLOW set). Other PCINSTRUCTION bits ignored.
//  Wrap-around: FIFO pointers ADDR_W bits, natural wrap; full/empty from count.
// STRUCTURE
//  Shared package/header: CLR_BIT default, EVENT_W=32, BYTES_PER_EVENT=4,
//   LENGTH_W=16, LENGTH_SAT=16'hFFFF.
//  One sub-module: event_word_fifo (sync FIFO, show-ahead, count output).
//  Serializer, byte-count, LENGTH latch and clear logic live in top level.
// TESTING
//  1 Write 32'hA1B2C3D4, ACCEPTED held 1 -> bytes A1,B2,C3,D4 on 4 edges,
//    AVAILIABLE then 0.
//  2 Write 3 words back-to-back, ACCEPTED held 1 -> 12 bytes, no idle cycle
//    between words; AVAILIABLE first high 2 cycles after first write.
//  3 Fill 1024 words, one more EVENT_VALID -> EVENT_READY=0, word dropped,
//    OVERFLOW=1; REQUEST_LENGTH -> LENGTH=16'd4096 (+4 if serializer loaded).
//  4 Serializer mid-word at idx=2, 5 words in FIFO, REQUEST_LENGTH -> LENGTH=22.
//  5 PCINSTRUCTION=8'h40 same cycle as EVENT_VALID and ACCEPTED -> next cycle
//    AVAILIABLE=0, EVENT_READY=1, OVERFLOW=0; next REQUEST_LENGTH -> LENGTH=0.
//  6 RESET asserted mid-word -> all outputs at reset values next edge; first
//    post-reset write emits its MSB byte first.

Source files
------------

// File: rtl/event_byte_packer_pkg.sv
// Package: event_byte_packer_pkg
// Purpose: shared widths and constants for the event byte packer.
//   CLR_BIT_DEF      PCINSTRUCTION bit that requests a buffer clear
//   FIFO_ADDR_W_DEF  log2 of the event-word FIFO depth
//   EVENT_W          width of one event record
//   BYTES_PER_EVENT  bytes emitted per event record
//   LENGTH_W         width of the LENGTH report
//   LENGTH_SAT       saturation value of the LENGTH report
package event_byte_packer_pkg;
    localparam int CLR_BIT_DEF     = 6;
    localparam int FIFO_ADDR_W_DEF = 10;
    localparam int EVENT_W         = 32;
    localparam int BYTES_PER_EVENT = 4;
    localparam int LENGTH_W        = 16;
    localparam logic [LENGTH_W-1:0] LENGTH_SAT = 16'hFFFF;
endpackage

// File: rtl/event_byte_packer_if.sv
// Interface: event_byte_packer_if
// Purpose: bundles the event-input, FX2 byte handshake, length report and
// PC command signals of the event byte packer.
//   master: the side driving events, ACCEPTED, REQUEST_LENGTH, PCINSTRUCTION
//   slave : the packer itself
interface event_byte_packer_if;
    import event_byte_packer_pkg::*;

    logic [EVENT_W-1:0]  EVENT_WORD;
    logic                EVENT_VALID;
    logic                EVENT_READY;
    logic [7:0]          FPGA_WORD;
    logic                FPGA_WORD_AVAILIABLE;
    logic                FPGA_WORD_ACCEPTED;
    logic                REQUEST_LENGTH;
    logic [LENGTH_W-1:0] LENGTH;
    logic [7:0]          PCINSTRUCTION;
    logic                OVERFLOW;

    modport master (
        output EVENT_WORD, EVENT_VALID, FPGA_WORD_ACCEPTED, REQUEST_LENGTH, PCINSTRUCTION,
        input  EVENT_READY, FPGA_WORD, FPGA_WORD_AVAILIABLE, LENGTH, OVERFLOW
    );

    modport slave (
        input  EVENT_WORD, EVENT_VALID, FPGA_WORD_ACCEPTED, REQUEST_LENGTH, PCINSTRUCTION,
        output EVENT_READY, FPGA_WORD, FPGA_WORD_AVAILIABLE, LENGTH, OVERFLOW
    );
endinterface

// File: rtl/event_byte_packer_fifo.sv
// Module: event_word_fifo
// Purpose: synchronous word FIFO with registered RAM read and a one-word
// show-ahead output register. The output register counts as FIFO storage,
// so total capacity is exactly 2**ADDR_W words.
//   clk, rst        clock, synchronous active-high reset
//   clr             synchronous flush
//   wr_en, wr_data  write port (caller guarantees ~full)
//   rd_en           pop the head word when rd_valid
//   rd_data         head word, valid when rd_valid
//   count           words stored (RAM + output register), 0..2**ADDR_W
//   full            count == 2**ADDR_W
module event_word_fifo
    import event_byte_packer_pkg::*;
#(
    parameter int DATA_W = EVENT_W,
    parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic              pop;
    logic              load_out;

    assign pop      = rd_en & rd_valid;
    // Refill the output register whenever it is (or is about to become) empty.
    // A word written this edge is not yet readable, hence ram_cnt, not wr_en.
    assign load_out = ~clr & (ram_cnt != '0) & (~rd_valid | pop);
    assign full     = (count == (ADDR_W+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
        if (load_out) begin
            rd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            rd_valid <= 1'b0;
            count    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load_out) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            ram_cnt  <= ram_cnt + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(load_out);
            rd_valid <= load_out | (rd_valid & ~pop);
            count    <= count + (ADDR_W+1)'(wr_en) - (ADDR_W+1)'(pop);
        end
    end
endmodule

// File: rtl/event_byte_packer.sv
// Module: event_byte_packer
// Purpose: buffers 32-bit event words and serialises them MSB-first into
// bytes on the FX2 FPGA_WORD handshake; reports buffered byte count on
// LENGTH when requested and executes the PC clear command.
//   FX2_CLK  single clock
//   RESET    synchronous active-high reset
//   bus      event_byte_packer_if.slave (events, byte handshake, LENGTH,
//            PCINSTRUCTION, OVERFLOW)
module event_byte_packer
    import event_byte_packer_pkg::*;
#(
    parameter int ADDR_W  = FIFO_ADDR_W_DEF,
    parameter int CLR_BIT = CLR_BIT_DEF
) (
    input  logic                FX2_CLK,
    input  logic                RESET,
    event_byte_packer_if.slave  bus
);
    logic                clr;
    logic                wr_en;
    logic                accept;
    logic                load_word;
    logic                fifo_valid;
    logic                fifo_full;
    logic [EVENT_W-1:0]  fifo_data;
    logic [ADDR_W:0]     fifo_count;
    logic [EVENT_W-1:0]  word_q;
    logic [1:0]          idx;
    logic                full_q;
    logic [7:0]          cur_byte;
    logic [LENGTH_W:0]   byte_count;
    logic [LENGTH_W-1:0] length_q;
    logic                overflow_q;

    function automatic logic [LENGTH_W-1:0] sat_len(input logic [LENGTH_W:0] v);
        return v[LENGTH_W] ? LENGTH_SAT : v[LENGTH_W-1:0];
    endfunction

    assign clr    = bus.PCINSTRUCTION[CLR_BIT];
    assign wr_en  = bus.EVENT_VALID & ~fifo_full & ~clr;
    assign accept = bus.FPGA_WORD_ACCEPTED & full_q;
    // Load when empty, or back-to-back when the last byte is being accepted.
    assign load_word = ~clr & fifo_valid & (~full_q | (accept & (idx == 2'd3)));

    event_word_fifo #(
        .DATA_W (EVENT_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk      (FX2_CLK),
        .rst      (RESET),
        .clr      (clr),
        .wr_en    (wr_en),
        .wr_data  (bus.EVENT_WORD),
        .rd_en    (load_word),
        .rd_data  (fifo_data),
        .rd_valid (fifo_valid),
        .count    (fifo_count),
        .full     (fifo_full)
    );

    // Serializer: word register, byte index, occupancy flag.
    always_ff @(posedge FX2_CLK) begin
        if (RESET || clr) begin
            word_q <= '0;
            idx    <= 2'd0;
            full_q <= 1'b0;
        end else if (load_word) begin
            word_q <= fifo_data;
            idx    <= 2'd0;
            full_q <= 1'b1;
        end else if (accept) begin
            if (idx == 2'd3) begin
                full_q <= 1'b0;
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

    always_comb begin
        cur_byte = word_q[31:24];
        case (idx)
            2'd0: cur_byte = word_q[31:24];
            2'd1: cur_byte = word_q[23:16];
            2'd2: cur_byte = word_q[15:8];
            2'd3: cur_byte = word_q[7:0];
            default: cur_byte = word_q[31:24];
        endcase
    end

    always_comb begin
        byte_count = (LENGTH_W+1)'(fifo_count) * (LENGTH_W+1)'(BYTES_PER_EVENT);
        if (full_q) begin
            byte_count = byte_count + (LENGTH_W+1)'(BYTES_PER_EVENT) - (LENGTH_W+1)'(idx);
        end
    end

    // LENGTH snapshot uses the pre-edge count; clear leaves it alone.
    always_ff @(posedge FX2_CLK) begin
        if (RESET) begin
            length_q <= '0;
        end else if (bus.REQUEST_LENGTH) begin
            length_q <= sat_len(byte_count);
        end
    end

    always_ff @(posedge FX2_CLK) begin
        if (RESET || clr) begin
            overflow_q <= 1'b0;
        end else if (bus.EVENT_VALID && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.EVENT_READY          = ~fifo_full;
    assign bus.FPGA_WORD            = cur_byte;
    assign bus.FPGA_WORD_AVAILIABLE = full_q;
    assign bus.LENGTH               = length_q;
    assign bus.OVERFLOW             = overflow_q;
endmodule

// File: tb/tb_event_byte_packer.sv
module tb_event_byte_packer;
    import event_byte_packer_pkg::*;

    logic FX2_CLK = 1'b0;
    logic RESET;

    event_byte_packer_if bus();

    event_byte_packer #(
        .ADDR_W  (10),
        .CLR_BIT (6)
    ) dut (
        .FX2_CLK (FX2_CLK),
        .RESET   (RESET),
        .bus     (bus)
    );

    always #5 FX2_CLK = ~FX2_CLK;

    int n_chk;
    int n_fail;

    // Reference model: stored words with their write edge, bytes of the word
    // currently on offer, and the two reported registers.
    logic [31:0] m_wq[$];
    int          m_wt[$];
    logic [7:0]  m_bq[$];
    logic [15:0] m_len;
    logic        m_ovf;
    int          cyc;

    typedef struct {
        logic        vld;
        logic [31:0] word;
        logic        acc;
        logic        req;
        logic [7:0]  pc;
        logic        e_av;
        logic [7:0]  e_byte;
        logic        e_rdy;
        logic [15:0] e_len;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(logic v, logic [31:0] w, logic a, logic r, logic [7:0] p,
                                logic eav, logic [7:0] eb, logic erdy, logic [15:0] el, logic eo);
        vec_t t;
        t.vld = v; t.word = w; t.acc = a; t.req = r; t.pc = p;
        t.e_av = eav; t.e_byte = eb; t.e_rdy = erdy; t.e_len = el; t.e_ovf = eo;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // A word becomes loadable into the serializer two edges after it was written.
    task automatic m_load();
        logic [31:0] w;
        if (m_wq.size() > 0 && cyc >= m_wt[0] + 2) begin
            w = m_wq.pop_front();
            void'(m_wt.pop_front());
            for (int b = 3; b >= 0; b--) m_bq.push_back(w[8*b +: 8]);
        end
    endtask

    task automatic m_flush();
        m_wq.delete();
        m_wt.delete();
        m_bq.delete();
    endtask

    task automatic model_edge();
        int  nb;
        logic room;
        cyc++;
        if (RESET) begin
            m_flush();
            m_len = 16'h0000;
            m_ovf = 1'b0;
            return;
        end
        nb = 4 * m_wq.size() + m_bq.size();
        if (bus.REQUEST_LENGTH) m_len = (nb > 65535) ? 16'hFFFF : 16'(nb);
        if (bus.PCINSTRUCTION[6]) begin
            m_flush();
            m_ovf = 1'b0;
            return;
        end
        room = (m_wq.size() < 1024);
        if (bus.EVENT_VALID && !room) m_ovf = 1'b1;
        if (m_bq.size() > 0) begin
            if (bus.FPGA_WORD_ACCEPTED) begin
                void'(m_bq.pop_front());
                if (m_bq.size() == 0) m_load();
            end
        end else begin
            m_load();
        end
        if (bus.EVENT_VALID && room) begin
            m_wq.push_back(bus.EVENT_WORD);
            m_wt.push_back(cyc);
        end
    endtask

    task automatic check_model();
        chk("model_avail", 32'(bus.FPGA_WORD_AVAILIABLE), 32'(m_bq.size() > 0));
        if (m_bq.size() > 0) chk("model_byte", 32'(bus.FPGA_WORD), 32'(m_bq[0]));
        chk("model_ready", 32'(bus.EVENT_READY), 32'(m_wq.size() < 1024));
        chk("model_length", 32'(bus.LENGTH), 32'(m_len));
        chk("model_overflow", 32'(bus.OVERFLOW), 32'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge FX2_CLK);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic a,
                         input logic r, input logic [7:0] p);
        bus.EVENT_VALID        = v;
        bus.EVENT_WORD         = w;
        bus.FPGA_WORD_ACCEPTED = a;
        bus.REQUEST_LENGTH     = r;
        bus.PCINSTRUCTION      = p;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        cycle();
        RESET = 1'b0;
    endtask

    initial begin
        logic [31:0] t2w[3];
        logic        hist[20];
        logic [7:0]  got[$];
        int          ones;
        int          accp;
        int          r;

        n_chk = 0; n_fail = 0; cyc = 0;
        m_len = 16'h0000; m_ovf = 1'b0;

        vecs[0]  = mk(1, 32'hA1B2C3D4, 1, 0, 8'h00, 0, 8'h00, 1, 16'd0, 0);
        vecs[1]  = mk(0, 32'h0,        1, 0, 8'h00, 0, 8'h00, 1, 16'd0, 0);
        vecs[2]  = mk(0, 32'h0,        1, 0, 8'h00, 1, 8'hA1, 1, 16'd0, 0);
        vecs[3]  = mk(0, 32'h0,        1, 0, 8'h00, 1, 8'hB2, 1, 16'd0, 0);
        vecs[4]  = mk(0, 32'h0,        1, 1, 8'h00, 1, 8'hC3, 1, 16'd3, 0);
        vecs[5]  = mk(0, 32'h0,        1, 0, 8'h00, 1, 8'hD4, 1, 16'd3, 0);
        vecs[6]  = mk(0, 32'h0,        1, 0, 8'h00, 0, 8'h00, 1, 16'd3, 0);
        vecs[7]  = mk(0, 32'h0,        0, 1, 8'h00, 0, 8'h00, 1, 16'd0, 0);
        vecs[8]  = mk(1, 32'h11223344, 1, 0, 8'h00, 0, 8'h00, 1, 16'd0, 0);
        vecs[9]  = mk(0, 32'h0,        0, 0, 8'h00, 0, 8'h00, 1, 16'd0, 0);
        vecs[10] = mk(0, 32'h0,        0, 0, 8'h00, 1, 8'h11, 1, 16'd0, 0);
        vecs[11] = mk(1, 32'h55667788, 1, 0, 8'h40, 0, 8'h00, 1, 16'd0, 0);
        vecs[12] = mk(0, 32'h0,        0, 1, 8'h00, 0, 8'h00, 1, 16'd0, 0);
        vecs[13] = mk(1, 32'hCAFEBABE, 0, 0, 8'hBF, 0, 8'h00, 1, 16'd0, 0);
        vecs[14] = mk(0, 32'h0,        0, 0, 8'h00, 0, 8'h00, 1, 16'd0, 0);
        vecs[15] = mk(0, 32'h0,        0, 0, 8'h00, 1, 8'hCA, 1, 16'd0, 0);
        vecs[16] = mk(0, 32'h0,        1, 1, 8'h00, 1, 8'hFE, 1, 16'd4, 0);
        vecs[17] = mk(0, 32'h0,        1, 0, 8'h00, 1, 8'hBA, 1, 16'd4, 0);

        // Reset state
        RESET = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        cycle();
        cycle();
        chk("rst_avail", 32'(bus.FPGA_WORD_AVAILIABLE), 32'd0);
        chk("rst_byte", 32'(bus.FPGA_WORD), 32'h00);
        chk("rst_ready", 32'(bus.EVENT_READY), 32'd1);
        chk("rst_length", 32'(bus.LENGTH), 32'h0000);
        chk("rst_overflow", 32'(bus.OVERFLOW), 32'd0);
        RESET = 1'b0;

        // Table: single word serialisation, length snapshots, clear, ignored PC bits
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].vld, vecs[i].word, vecs[i].acc, vecs[i].req, vecs[i].pc);
            cycle();
            chk($sformatf("vec%0d_avail", i), 32'(bus.FPGA_WORD_AVAILIABLE), 32'(vecs[i].e_av));
            if (vecs[i].e_av) chk($sformatf("vec%0d_byte", i), 32'(bus.FPGA_WORD), 32'(vecs[i].e_byte));
            chk($sformatf("vec%0d_ready", i), 32'(bus.EVENT_READY), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_length", i), 32'(bus.LENGTH), 32'(vecs[i].e_len));
            chk($sformatf("vec%0d_overflow", i), 32'(bus.OVERFLOW), 32'(vecs[i].e_ovf));
        end

        // Three back-to-back words with ACCEPTED held high
        do_reset();
        t2w[0] = 32'h01020304; t2w[1] = 32'hF0E0D0C0; t2w[2] = 32'h5A6B7C8D;
        for (int k = 0; k < 20; k++) begin
            drive(k < 3, (k < 3) ? t2w[k] : 32'h0, 1'b1, 1'b0, 8'h00);
            cycle();
            hist[k] = bus.FPGA_WORD_AVAILIABLE;
            if (bus.FPGA_WORD_AVAILIABLE) got.push_back(bus.FPGA_WORD);
        end
        ones = 0;
        for (int k = 0; k < 20; k++) ones += int'(hist[k]);
        chk("t2_avail_cycles", 32'(ones), 32'd12);
        chk("t2_avail_k1", 32'(hist[1]), 32'd0);
        chk("t2_avail_k2", 32'(hist[2]), 32'd1);
        chk("t2_avail_k13", 32'(hist[13]), 32'd1);
        chk("t2_avail_k14", 32'(hist[14]), 32'd0);
        chk("t2_nbytes", 32'(got.size()), 32'd12);
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            logic [31:0] w;
            w = t2w[i / 4];
            chk($sformatf("t2_byte%0d", i), 32'(got[i]), 32'(w[8*(3 - i % 4) +: 8]));
        end

        // Serializer at idx 2 with 5 words queued
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 32'h10000000 + 32'(k), 1'b0, 1'b0, 8'h00);
            cycle();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 8'h00);
        cycle();
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 8'h00);
        cycle();
        chk("t4_length", 32'(bus.LENGTH), 32'd22);

        // Fill to capacity, overflow, length, drain with wrap, clear while busy
        do_reset();
        for (int k = 0; k < 1030; k++) begin
            drive(1'b1, $urandom, 1'b0, 1'b0, 8'h00);
            cycle();
        end
        chk("t3_ready", 32'(bus.EVENT_READY), 32'd0);
        chk("t3_overflow", 32'(bus.OVERFLOW), 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 8'h00);
        cycle();
        chk("t3_length", 32'(bus.LENGTH), 32'd4100);
        for (int k = 0; k < 2000; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 8'h00);
            cycle();
        end
        chk("t3_overflow_held", 32'(bus.OVERFLOW), 32'd1);
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 8'h40);
        cycle();
        chk("t5_avail", 32'(bus.FPGA_WORD_AVAILIABLE), 32'd0);
        chk("t5_ready", 32'(bus.EVENT_READY), 32'd1);
        chk("t5_overflow", 32'(bus.OVERFLOW), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 8'h00);
        cycle();
        chk("t5_length", 32'(bus.LENGTH), 32'd0);

        // Reset in the middle of a word
        do_reset();
        drive(1'b1, 32'h0F1E2D3C, 1'b0, 1'b0, 8'h00);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        cycle();
        cycle();
        drive(1'b0, 32'h0, 1'b1, 1'b1, 8'h00);
        cycle();
        chk("t6_pre_byte", 32'(bus.FPGA_WORD), 32'h1E);
        chk("t6_pre_length", 32'(bus.LENGTH), 32'd4);
        RESET = 1'b1;
        drive(1'b1, 32'h12345678, 1'b1, 1'b1, 8'h00);
        cycle();
        chk("t6_rst_avail", 32'(bus.FPGA_WORD_AVAILIABLE), 32'd0);
        chk("t6_rst_byte", 32'(bus.FPGA_WORD), 32'h00);
        chk("t6_rst_ready", 32'(bus.EVENT_READY), 32'd1);
        chk("t6_rst_length", 32'(bus.LENGTH), 32'd0);
        chk("t6_rst_overflow", 32'(bus.OVERFLOW), 32'd0);
        RESET = 1'b0;
        drive(1'b1, 32'h89ABCDEF, 1'b0, 1'b0, 8'h00);
        cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 8'h00);
        cycle();
        cycle();
        chk("t6_post_avail", 32'(bus.FPGA_WORD_AVAILIABLE), 32'd1);
        chk("t6_post_byte", 32'(bus.FPGA_WORD), 32'h89);

        // Randomised traffic against the model
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            accp = (blk % 2 == 0) ? 8 : 2;
            for (int k = 0; k < 500; k++) begin
                logic [7:0] p;
                r = $urandom_range(0, 999);
                if (r == 0)       p = 8'h40;
                else if (r < 20)  p = 8'($urandom) & 8'hBF;
                else              p = 8'h00;
                drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < accp,
                      $urandom_range(0, 9) == 0, p);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
